// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 mux slice.
// Ports: clk, rst_n (async low), req[3:0] in; sel[1:0], gnt[3:0], busy out.
//   req  - request per mux input a..d (bit 0..3)
//   sel  - registered mux select
//   gnt  - registered one-hot grant, zero when no owner
//   busy - arbiter is in SWITCH or GRANT
module mux4_rr_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = $clog2(BURST_LEN) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SWITCH,
        GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             burst_done;
    logic             rel;

    // First requester after 'last', wrapping; 'last' itself is
    // visited at the end so the previous owner has lowest priority.
    function automatic logic [1:0] pick(
        input logic [3:0] r,
        input logic [1:0] last
    );
        logic [1:0] idx;
        logic [1:0] w;
        logic       found;
        w     = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign burst_done = (cnt_q == CNT_W'(BURST_LEN - 1));
    assign rel        = !req[sel] || burst_done;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        sel_d   = sel;
        gnt_d   = gnt;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = SWITCH;
                    sel_d   = pick(req, last_q);
                end
            end
            SWITCH: begin
                if (req[sel]) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << sel;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + 1'b1;
                if (rel) begin
                    gnt_d  = '0;
                    last_d = sel;
                    if (|req) begin
                        // Lone requester re-picks itself: sel unchanged.
                        state_d = SWITCH;
                        sel_d   = pick(req, sel);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel     <= 2'd0;
            gnt     <= 4'd0;
            cnt_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            sel     <= sel_d;
            gnt     <= gnt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench for mux4_rr_arbiter.
// Reference model pushes expected outputs; negedge monitor pops and compares.
module tb_mux4_rr_arbiter;

    localparam int BL = 4;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       busy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;

    int n_checks;
    int n_fail;

    exp_t exp_q[$];
    int   order_q[$];

    mux4_rr_arbiter #(.BURST_LEN(BL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .sel  (sel),
        .gnt  (gnt),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 = no owner, 1 = settle gap, 2 = owner holds grant
    int m_phase;
    int m_sel;
    int m_last;
    int m_left;

    function automatic int next_owner(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return last;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        logic [3:0] r;
        if (!rst_n) begin
            m_phase = 0;
            m_sel   = 0;
            m_last  = 3;
            m_left  = 0;
            exp_q.delete();
        end else begin
            r = req;
            if (m_phase == 0) begin
                if (r != 0) begin
                    m_phase = 1;
                    m_sel   = next_owner(r, m_last);
                end
            end else if (m_phase == 1) begin
                if (r[m_sel]) begin
                    m_phase = 2;
                    m_left  = BL;
                end else begin
                    m_phase = 0;
                end
            end else begin
                m_left = m_left - 1;
                if (!r[m_sel] || m_left == 0) begin
                    m_last = m_sel;
                    if (r != 0) begin
                        m_phase = 1;
                        m_sel   = next_owner(r, m_last);
                    end else begin
                        m_phase = 0;
                    end
                end
            end
            e.sel  = 2'(m_sel);
            e.gnt  = (m_phase == 2) ? (4'b0001 << m_sel) : 4'b0000;
            e.busy = (m_phase != 0);
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    logic [1:0] prev_sel;
    logic [3:0] prev_gnt;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            n_checks++;
            if (sel !== 2'd0 || gnt !== 4'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state t=%0t sel=%0d gnt=%b busy=%b need 0/0000/0",
                         $time, sel, gnt, busy);
            end
        end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty t=%0t no expected entry", $time);
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (sel !== e.sel || gnt !== e.gnt || busy !== e.busy) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got sel=%0d gnt=%b busy=%b need sel=%0d gnt=%b busy=%b",
                         $time, sel, gnt, busy, e.sel, e.gnt, e.busy);
            end
        end
        n_checks++;
        if (!$onehot0(gnt)) begin
            n_fail++;
            $display("FAIL gnt_onehot t=%0t gnt=%b need one-hot or zero", $time, gnt);
        end
        if (gnt != 0 && prev_gnt != 0) begin
            n_checks++;
            if (sel !== prev_sel) begin
                n_fail++;
                $display("FAIL sel_stable t=%0t sel=%0d need %0d while granted",
                         $time, sel, prev_sel);
            end
        end
        if (gnt != 0 && prev_gnt == 0) begin
            for (int i = 0; i < 4; i++) if (gnt[i]) order_q.push_back(i);
        end
        prev_sel = sel;
        prev_gnt = gnt;
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [3:0] r, input int n);
        req = r;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check(input string name, input int got, input int need);
        n_checks++;
        if (got != need) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d need %0d", name, $time, got, need);
        end
    endtask

    initial begin
        int exp_order[5];
        logic [3:0] r;
        n_checks = 0;
        n_fail   = 0;
        prev_sel = 2'd0;
        prev_gnt = 4'd0;
        req      = 4'b0000;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // idle hold
        hold(4'b0000, 5);

        // single requester latency
        hold(4'b0100, 1);
        check("lat_sel", sel, 2);
        check("lat_gnt_settle", gnt, 0);
        hold(4'b0100, 1);
        check("lat_gnt", gnt, 4'b0100);
        hold(4'b0000, 1);
        check("drop_gnt", gnt, 0);
        hold(4'b0000, 2);

        // full contention round robin from reset priority
        do_reset();
        order_q.delete();
        hold(4'b1111, 25);
        exp_order = '{0, 1, 2, 3, 0};
        check("order_len", (order_q.size() >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < order_q.size()) check("order", order_q[i], exp_order[i]);
        end
        hold(4'b0000, 3);

        // lone requester bursts
        hold(4'b0001, 12);
        hold(4'b0000, 2);

        // no preemption
        hold(4'b0010, 3);
        check("owner1", gnt, 4'b0010);
        hold(4'b0011, 2);
        check("no_preempt", gnt, 4'b0010);
        hold(4'b0011, 6);
        hold(4'b0000, 3);

        // one-cycle pulse, never granted
        hold(4'b1000, 1);
        check("pulse_sel", sel, 3);
        hold(4'b0000, 3);
        check("pulse_gnt", gnt, 0);

        // async reset mid-grant
        hold(4'b0010, 3);
        check("pre_rst_gnt", gnt, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", gnt, 0);
        check("async_rst_busy", busy, 0);
        req = 4'b1010;
        @(negedge clk);
        #1 rst_n = 1'b1;
        hold(4'b1010, 1);
        check("post_rst_sel", sel, 1);
        hold(4'b1010, 1);
        check("post_rst_gnt", gnt, 4'b0010);
        hold(4'b0000, 3);

        // randomized traffic
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
            hold(r, 1);
        end
        hold(4'b0000, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
